// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver (and the future transmitter).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } uart_rx_state_t;

    // 0 data bits makes no sense on the wire; treat it as a single bit.
    function automatic logic [5:0] clamp_bits(input logic [5:0] req, input logic [5:0] max_bits);
        if (req == 6'd0) begin
            return 6'd1;
        end else if (req > max_bits) begin
            return max_bits;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Bus bundle for uart_rx_os; parity signals exist only with UART_RX_PARITY_EN.
// rx_done is a valid-only strobe: dout/frame_err/parity_err are valid in the cycle it is high, no ready.
interface uart_rx_os_if #(
    parameter int MAX_WORD_SIZE = 8,
    parameter int DIV_W         = 16
);
    import uart_pkg::*;

    logic                     rx;
    logic [5:0]               rx_bits;
    logic [DIV_W-1:0]         baud_div;
    logic [MAX_WORD_SIZE-1:0] dout;
    logic                     rx_done;
    logic                     frame_err;
    uart_rx_state_t           state;
`ifdef UART_RX_PARITY_EN
    logic                     parity_odd;
    logic                     parity_err;

    modport master (output rx, rx_bits, baud_div, parity_odd,
                    input  dout, rx_done, frame_err, parity_err, state);
    modport slave  (input  rx, rx_bits, baud_div, parity_odd,
                    output dout, rx_done, frame_err, parity_err, state);
`else
    modport master (output rx, rx_bits, baud_div,
                    input  dout, rx_done, frame_err, state);
    modport slave  (input  rx, rx_bits, baud_div,
                    output dout, rx_done, frame_err, state);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Programmable oversample tick: fires when the count reaches div-1; div=0 behaves as 1.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;

    assign lim  = (div == '0) ? '0 : div - 1'b1;
    assign tick = !clear && (cnt == lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with false-start rejection and stop-bit framing check.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = 8,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE_DEF,
    parameter int DIV_W         = 16
) (
    input logic        clk,
    input logic        rst,
    uart_rx_os_if.slave bus
);
    localparam int              OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MID_CNT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] LAST_CNT = OS_W'(OVERSAMPLE - 1);
    localparam logic [5:0]      MAX_BITS = 6'(MAX_WORD_SIZE);

    uart_rx_state_t           state, next_state;
    logic                     sync1, rx_s;
    logic [DIV_W-1:0]         div_q;
    logic [5:0]               nbits_q, bit_idx;
    logic [OS_W-1:0]          os_cnt;
    logic [MAX_WORD_SIZE-1:0] shreg;
    logic                     tick, sample, start_edge, last_bit;
`ifdef UART_RX_PARITY_EN
    logic                     par_pend;
`endif

    assign bus.state = state;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // START samples half a bit in; every later sample is one full bit apart.
    always_comb begin
        next_state = state;
        start_edge = 1'b0;
        last_bit   = (bit_idx == nbits_q - 6'd1);
        sample     = tick && (os_cnt == ((state == START) ? MID_CNT : LAST_CNT));
        case (state)
            IDLE: if (!rx_s) begin
                next_state = START;
                start_edge = 1'b1;
            end
            START:   if (sample) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (sample && last_bit) next_state = PARITY;
            PARITY:  if (sample) next_state = STOP;
`else
            DATA:    if (sample && last_bit) next_state = STOP;
`endif
            STOP:    if (sample) next_state = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            div_q         <= '0;
            nbits_q       <= 6'd1;
            bit_idx       <= '0;
            os_cnt        <= '0;
            shreg         <= '0;
            bus.dout      <= '0;
            bus.rx_done   <= 1'b0;
            bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend       <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            sync1       <= bus.rx;
            rx_s        <= sync1;
            bus.rx_done <= 1'b0;

            if (state == IDLE)  os_cnt <= '0;
            else if (tick)      os_cnt <= sample ? '0 : os_cnt + 1'b1;

            if (start_edge) begin
                div_q   <= bus.baud_div;
                nbits_q <= clamp_bits(bus.rx_bits, MAX_BITS);
                bit_idx <= '0;
                shreg   <= '0;
`ifdef UART_RX_PARITY_EN
                par_pend <= 1'b0;
`endif
            end

            // LSB arrives first and ends up right-justified once the stop bit is seen.
            if (state == DATA && sample) begin
                shreg   <= {rx_s, shreg[MAX_WORD_SIZE-1:1]};
                bit_idx <= bit_idx + 6'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && sample) par_pend <= rx_s ^ (^shreg) ^ bus.parity_odd;
`endif

            if (state == STOP && sample) begin
                bus.rx_done   <= 1'b1;
                bus.dout      <= shreg >> (MAX_BITS - nbits_q);
                bus.frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                bus.parity_err <= par_pend;
`endif
            end
        end
    end
endmodule
